// File: rtl/hilo_pipe_unit_pkg.sv
// Shared definitions for the HI/LO pipeline unit: bus width, reset level,
// stall-vector layout and the pending-write record carried down the pipe.
package hilo_pipe_unit_pkg;

    // Width of the HI and LO registers.
    localparam int DATA_BUS = 32;

    // Level of rst that means "in reset".
    localparam logic RST_ENABLE = 1'b0;

    // Bit positions inside the internal stall vector.
    localparam int STALL_EX  = 0;
    localparam int STALL_MEM = 1;
    localparam int STALL_W   = 2;

    // One pending HI/LO write as it travels from EX towards commit.
    typedef struct packed {
        logic                hi_we;
        logic                lo_we;
        logic [DATA_BUS-1:0] hi;
        logic [DATA_BUS-1:0] lo;
    } hilo_wr_t;

endpackage

// File: rtl/hilo_pipe_unit_if.sv
// EX-side bus of the HI/LO pipeline unit: pending write from EX, pipeline
// control, forwarded values back to EX and the committed HI/LO.
// master = the EX/control side, slave = hilo_pipe_unit.
interface hilo_pipe_unit_if
    import hilo_pipe_unit_pkg::*;
#(
    parameter int DATA_W = DATA_BUS
) ();

    logic              ex_hi_we;
    logic              ex_lo_we;
    logic [DATA_W-1:0] ex_hi_data;
    logic [DATA_W-1:0] ex_lo_data;
    logic              ex_stall;
    logic              mem_stall;
    logic              flush;
    logic [DATA_W-1:0] hi_val_mux_data;
    logic [DATA_W-1:0] lo_val_mux_data;
    logic [DATA_W-1:0] hi_arch;
    logic [DATA_W-1:0] lo_arch;

    modport master (
        output ex_hi_we, ex_lo_we, ex_hi_data, ex_lo_data,
        output ex_stall, mem_stall, flush,
        input  hi_val_mux_data, lo_val_mux_data, hi_arch, lo_arch
    );

    modport slave (
        input  ex_hi_we, ex_lo_we, ex_hi_data, ex_lo_data,
        input  ex_stall, mem_stall, flush,
        output hi_val_mux_data, lo_val_mux_data, hi_arch, lo_arch
    );

endinterface

// File: rtl/hilo_stage_reg.sv
// One pipeline slot holding a pending HI/LO write.
// bubble clears the slot (write enables and data to 0) and wins over hold;
// hold keeps the current contents; otherwise the slot loads its inputs.
module hilo_stage_reg
    import hilo_pipe_unit_pkg::*;
#(
    parameter int W = DATA_BUS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic         hold,
    input  logic         d_hi_we,
    input  logic         d_lo_we,
    input  logic [W-1:0] d_hi,
    input  logic [W-1:0] d_lo,
    output logic         q_hi_we,
    output logic         q_lo_we,
    output logic [W-1:0] q_hi,
    output logic [W-1:0] q_lo
);

    // Slot register: clear on reset or bubble, keep on hold, else load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_hi_we <= 1'b0;
            q_lo_we <= 1'b0;
            q_hi    <= '0;
            q_lo    <= '0;
        end else if (bubble) begin
            q_hi_we <= 1'b0;
            q_lo_we <= 1'b0;
            q_hi    <= '0;
            q_lo    <= '0;
        end else if (!hold) begin
            q_hi_we <= d_hi_we;
            q_lo_we <= d_lo_we;
            q_hi    <= d_hi;
            q_lo    <= d_lo;
        end
    end

endmodule

// File: rtl/hilo_pipe_unit.sv
// HI/LO pipeline unit: carries pending HI/LO writes from EX through MEM and
// WB, commits WB into the architectural HI/LO, and forwards the youngest
// pending value (MEM, then WB, then architectural) back to EX.
module hilo_pipe_unit
    import hilo_pipe_unit_pkg::*;
#(
    parameter int DATA_W = DATA_BUS
) (
    input  logic             clk,
    input  logic             rst,
    hilo_pipe_unit_if.slave  bus
);

    logic [STALL_W-1:0] stall;

    logic              mem_bubble;
    logic              mem_hold;
    logic              wb_bubble;

    logic              mem_hi_we;
    logic              mem_lo_we;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;

    logic              wb_hi_we;
    logic              wb_lo_we;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;

    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;

    logic [DATA_W-1:0] hi_fwd;
    logic [DATA_W-1:0] lo_fwd;

    assign stall[STALL_EX]  = bus.ex_stall;
    assign stall[STALL_MEM] = bus.mem_stall;

    // Slot controls. flush empties both slots; a MEM stall freezes MEM and
    // sends a bubble to WB (and dominates an EX stall); an EX stall alone
    // lets MEM advance into WB but feeds MEM a bubble.
    always_comb begin
        mem_bubble = 1'b0;
        mem_hold   = 1'b0;
        wb_bubble  = 1'b0;
        if (bus.flush) begin
            mem_bubble = 1'b1;
            wb_bubble  = 1'b1;
        end else if (stall[STALL_MEM]) begin
            mem_hold   = 1'b1;
            wb_bubble  = 1'b1;
        end else if (stall[STALL_EX]) begin
            mem_bubble = 1'b1;
        end
    end

    hilo_stage_reg #(.W(DATA_W)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .bubble  (mem_bubble),
        .hold    (mem_hold),
        .d_hi_we (bus.ex_hi_we),
        .d_lo_we (bus.ex_lo_we),
        .d_hi    (bus.ex_hi_data),
        .d_lo    (bus.ex_lo_data),
        .q_hi_we (mem_hi_we),
        .q_lo_we (mem_lo_we),
        .q_hi    (mem_hi),
        .q_lo    (mem_lo)
    );

    hilo_stage_reg #(.W(DATA_W)) u_wb (
        .clk     (clk),
        .rst     (rst),
        .bubble  (wb_bubble),
        .hold    (1'b0),
        .d_hi_we (mem_hi_we),
        .d_lo_we (mem_lo_we),
        .d_hi    (mem_hi),
        .d_lo    (mem_lo),
        .q_hi_we (wb_hi_we),
        .q_lo_we (wb_lo_we),
        .q_hi    (wb_hi),
        .q_lo    (wb_lo)
    );

    // Architectural commit from WB; WB was filled before flush/stall was
    // sampled, so it always commits. HI and LO are independent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            if (wb_hi_we) begin
                hi_r <= wb_hi;
            end
            if (wb_lo_we) begin
                lo_r <= wb_lo;
            end
        end
    end

    // Forwarding: the youngest pending write wins, chosen per register.
    always_comb begin
        hi_fwd = hi_r;
        lo_fwd = lo_r;
        if (mem_hi_we) begin
            hi_fwd = mem_hi;
        end else if (wb_hi_we) begin
            hi_fwd = wb_hi;
        end
        if (mem_lo_we) begin
            lo_fwd = mem_lo;
        end else if (wb_lo_we) begin
            lo_fwd = wb_lo;
        end
    end

    assign bus.hi_val_mux_data = (rst == RST_ENABLE) ? '0 : hi_fwd;
    assign bus.lo_val_mux_data = (rst == RST_ENABLE) ? '0 : lo_fwd;
    assign bus.hi_arch         = hi_r;
    assign bus.lo_arch         = lo_r;

endmodule
